// File: rtl/glcd_pkg.sv
// Shared constants for the graphic LCD text path.
// Holds the panel geometry defaults, the character cell shape, the ASCII
// codes the writer treats specially, and the writer FSM state encoding.
package glcd_pkg;

  localparam int GLCD_COLS  = 128;
  localparam int GLCD_PAGES = 8;

  localparam int CHAR_W     = 5;
  localparam int CHAR_GAP   = 1;
  localparam int CHAR_PITCH = CHAR_W + CHAR_GAP;

  localparam logic [7:0] ASCII_BASE = 8'h20;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // Codes 0x20..0x7F have a glyph in the font ROM.
  function automatic logic is_printable(input logic [7:0] c);
    return (c[7] == 1'b0) && (c >= ASCII_BASE);
  endfunction

  function automatic logic is_newline(input logic [7:0] c);
    return (c == ASCII_LF) || (c == ASCII_CR);
  endfunction

endpackage

// File: rtl/glcd_cursor.sv
// Page/column text cursor for the GLCD character writer.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   advance      : a full character cell was emitted; step one pitch
//   newline      : move to column 0 of the next page
//   home         : force cursor to page 0 / column 0 (applied before newline,
//                  and overriding the result of an advance)
//   page, col    : current cursor position
module glcd_cursor
  import glcd_pkg::*;
#(
  parameter int GLCD_COLS  = glcd_pkg::GLCD_COLS,
  parameter int GLCD_PAGES = glcd_pkg::GLCD_PAGES,
  localparam int COL_W     = $clog2(GLCD_COLS),
  localparam int PAGE_W    = $clog2(GLCD_PAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              newline,
  input  logic              home,
  output logic [PAGE_W-1:0] page,
  output logic [COL_W-1:0]  col
);

  logic [PAGE_W-1:0] page_q, page_d;
  logic [COL_W-1:0]  col_q, col_d;
  int                adv_col;

  function automatic logic [PAGE_W-1:0] next_page(input logic [PAGE_W-1:0] p);
    return (p == PAGE_W'(GLCD_PAGES - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    page_d  = page_q;
    col_d   = col_q;
    adv_col = int'(col_q) + CHAR_PITCH;
    if (advance && !home) begin
      // Wrap as soon as another full cell would not fit on this line.
      if (adv_col + CHAR_PITCH > GLCD_COLS) begin
        col_d  = '0;
        page_d = next_page(page_q);
      end else begin
        col_d  = COL_W'(adv_col);
      end
    end else if (newline) begin
      col_d  = '0;
      page_d = next_page(home ? '0 : page_q);
    end else if (home) begin
      col_d  = '0;
      page_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      page_q <= '0;
      col_q  <= '0;
    end else begin
      page_q <= page_d;
      col_q  <= col_d;
    end
  end

  assign page = page_q;
  assign col  = col_q;

endmodule

// File: rtl/glcd_char_writer.sv
// Text-to-pixel front end for the GLCD path. Accepts one ASCII character per
// valid/ready handshake, looks up its 5-column glyph in the external font ROM
// and streams six column bytes (glyph + one blank gap) to the bus driver,
// tracking the page/column cursor with wrap and newline handling.
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   char_in/valid/ready     : character input handshake
//   home                    : single-cycle request to move cursor to 0/0
//   R_A / R_D               : font ROM address (from char_in) / glyph data
//   col_data/page/addr      : column byte (LSB = top pixel) and its position
//   col_valid / col_ready   : column output handshake
module glcd_char_writer
  import glcd_pkg::*;
#(
  parameter int GLCD_COLS  = glcd_pkg::GLCD_COLS,
  parameter int GLCD_PAGES = glcd_pkg::GLCD_PAGES,
  localparam int COL_W     = $clog2(GLCD_COLS),
  localparam int PAGE_W    = $clog2(GLCD_PAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              home,
  output logic [6:0]        R_A,
  input  logic [39:0]       R_D,
  output logic [7:0]        col_data,
  output logic [PAGE_W-1:0] col_page,
  output logic [COL_W-1:0]  col_addr,
  output logic              col_valid,
  input  logic              col_ready
);

  logic [0:0]        state_q;
  logic [2:0]        idx_q;
  logic [39:0]       glyph_q;
  logic              home_pend_q;

  logic              accept;
  logic              nl_char;
  logic              xfer;
  logic              last_xfer;
  logic              cur_home;
  logic [PAGE_W-1:0] page;
  logic [COL_W-1:0]  col;

  assign nl_char    = is_newline(char_in);
  assign R_A        = is_printable(char_in) ? 7'(char_in - ASCII_BASE) : 7'd0;

  assign char_ready = reset && (state_q == ST_IDLE);
  assign col_valid  = reset && (state_q == ST_EMIT);
  assign accept     = char_valid && char_ready;
  assign xfer       = col_valid && col_ready;
  assign last_xfer  = xfer && (idx_q == 3'(CHAR_PITCH - 1));

  // In IDLE home takes effect immediately (ahead of a same-cycle accept);
  // during EMIT it waits for the gap byte and then overrides the wrap.
  assign cur_home   = ((state_q == ST_IDLE) && home) ||
                      (last_xfer && (home || home_pend_q));

  glcd_cursor #(
    .GLCD_COLS  (GLCD_COLS),
    .GLCD_PAGES (GLCD_PAGES)
  ) u_cursor (
    .clk     (clk),
    .reset   (reset),
    .advance (last_xfer),
    .newline (accept && nl_char),
    .home    (cur_home),
    .page    (page),
    .col     (col)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      glyph_q     <= '0;
      home_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          home_pend_q <= 1'b0;
          if (accept && !nl_char) begin
            // R_D is only trusted in the accept cycle; keep a private copy.
            glyph_q <= R_D;
            idx_q   <= '0;
            state_q <= ST_EMIT;
          end
        end
        default: begin
          if (home) home_pend_q <= 1'b1;
          if (xfer) idx_q <= idx_q + 3'd1;
          if (last_xfer) begin
            idx_q       <= '0;
            home_pend_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    col_data = 8'h00;
    if (col_valid) begin
      case (idx_q)
        3'd0:    col_data = glyph_q[39:32];
        3'd1:    col_data = glyph_q[31:24];
        3'd2:    col_data = glyph_q[23:16];
        3'd3:    col_data = glyph_q[15:8];
        3'd4:    col_data = glyph_q[7:0];
        default: col_data = 8'h00;
      endcase
    end
  end

  assign col_page = reset ? page : '0;
  assign col_addr = reset ? (col + COL_W'(idx_q)) : '0;

endmodule

// File: tb/tb_glcd_char_writer.sv
// Scoreboard bench for glcd_char_writer with a small font ROM model.
module tb_glcd_char_writer;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] p;
    logic [6:0] a;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        home;
  logic [6:0]  R_A;
  logic [39:0] R_D;
  logic [7:0]  col_data;
  logic [2:0]  col_page;
  logic [6:0]  col_addr;
  logic        col_valid;
  logic        col_ready;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   m_page = 0;
  int   m_col  = 0;

  glcd_char_writer dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .home       (home),
    .R_A        (R_A),
    .R_D        (R_D),
    .col_data   (col_data),
    .col_page   (col_page),
    .col_addr   (col_addr),
    .col_valid  (col_valid),
    .col_ready  (col_ready)
  );

  function automatic logic [39:0] rom_glyph(input logic [6:0] a);
    case (a)
      7'd0:    return 40'h0;
      7'd33:   return 40'h7E1111117E;  // 'A'
      7'd34:   return 40'h7F49494936;  // 'B'
      7'd88:   return 40'h4428102844;  // 'x'
      default: return {5{1'b1, a}};
    endcase
  endfunction

  assign R_D = rom_glyph(R_A);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Send one character; rmode 0 = col_ready high, 1 = toggling 1,0.
  // home_at / rst_at: column index (on display) at which to pulse home or
  // assert reset; -1 disables. chk_lat enables the exact latency checks.
  task automatic run_char(input logic [7:0] c, input int rmode, input int home_at,
                          input int rst_at, input int chk_lat);
    logic [6:0]  ra;
    logic [39:0] g;
    logic [7:0]  b;
    exp_t        e;
    bit          nl, done, hd, rst_hit;
    int          cyc, nx;
    nl = (c == 8'h0A) || (c == 8'h0D);
    ra = (c >= 8'h20 && c <= 8'h7F) ? 7'(c - 8'h20) : 7'd0;
    g  = rom_glyph(ra);
    if (!nl) begin
      for (int i = 0; i < 6; i++) begin
        b = (i < 5) ? g[39 - 8*i -: 8] : 8'h00;
        exp_q.push_back({b, 3'(m_page), 7'(m_col + i)});
      end
    end
    @(negedge clk);
    char_in = c; char_valid = 1'b1; col_ready = 1'b1;
    #1;
    total++;
    if (char_ready !== 1'b1) begin
      bad++; $display("FAIL ready_before_accept: got=%b want=1", char_ready);
    end
    total++;
    if (R_A !== ra) begin
      bad++; $display("FAIL rom_addr c=%h: got=%0d want=%0d", c, R_A, ra);
    end
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    if (nl) begin
      total++;
      if ({col_valid, char_ready} !== 2'b01) begin
        bad++; $display("FAIL newline_no_output: valid/ready got=%b%b want=01", col_valid, char_ready);
      end
      m_col = 0; m_page = (m_page + 1) % 8;
      return;
    end
    cyc = 1; nx = 0; done = 0; hd = 0; rst_hit = 0;
    while (!done && cyc < 60) begin
      if (nx == 6) begin
        total++;
        if ({char_ready, col_valid} !== 2'b10) begin
          bad++; $display("FAIL ready_after_char: ready/valid got=%b%b want=10", char_ready, col_valid);
        end
        if (chk_lat != 0) begin
          total++;
          if (cyc != 7) begin
            bad++; $display("FAIL ready_latency: got=%0d want=7", cyc);
          end
        end
        done = 1;
      end else if (rst_at >= 0 && nx == rst_at) begin
        reset = 1'b0;
        #1;
        total++;
        if ({col_valid, char_ready, col_data, col_page, col_addr} !== 20'h0) begin
          bad++;
          $display("FAIL reset_outputs: valid=%b ready=%b data=%h page=%0d addr=%0d want all 0",
                   col_valid, char_ready, col_data, col_page, col_addr);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        m_page = 0; m_col = 0;
        rst_hit = 1; done = 1;
      end else begin
        col_ready = (rmode == 1) ? ((cyc % 2) == 1) : 1'b1;
        home = (nx == home_at && !hd) ? 1'b1 : 1'b0;
        if (home) hd = 1;
        if (chk_lat != 0 && cyc == 1) begin
          total++;
          if (col_valid !== 1'b1) begin
            bad++; $display("FAIL first_col_latency: valid got=%b want=1", col_valid);
          end
        end
        if (col_valid === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL extra_col: data=%h page=%0d addr=%0d want none", col_data, col_page, col_addr);
          end else begin
            e = exp_q[0];
            if ({col_data, col_page, col_addr} !== e) begin
              bad++;
              $display("FAIL col_out: data=%h page=%0d addr=%0d want data=%h page=%0d addr=%0d",
                       col_data, col_page, col_addr, e.d, e.p, e.a);
            end
            if (col_ready) begin
              void'(exp_q.pop_front());
              nx++;
            end
          end
          total++;
          if (col_addr > 7'd125) begin
            bad++; $display("FAIL col_range: addr=%0d want<=125", col_addr);
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    home = 1'b0; col_ready = 1'b1;
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout c=%h: sent=%0d want=6", c, nx);
    end
    if (!rst_hit) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++; $display("FAIL leftover_cols: got=%0d want=0", exp_q.size());
      end
      if (hd) begin
        m_page = 0; m_col = 0;
      end else begin
        m_col = m_col + 6;
        if (m_col + 6 > 128) begin
          m_col = 0; m_page = (m_page + 1) % 8;
        end
      end
    end
  endtask

  task automatic pulse_home();
    @(negedge clk);
    home = 1'b1;
    @(negedge clk);
    home = 1'b0;
    total++;
    if ({char_ready, col_valid} !== 2'b10) begin
      bad++; $display("FAIL home_idle: ready/valid got=%b%b want=10", char_ready, col_valid);
    end
    m_page = 0; m_col = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; char_in = 8'h00; char_valid = 1'b0; home = 1'b0; col_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({col_valid, char_ready, col_data, col_page, col_addr} !== 20'h0) begin
      bad++;
      $display("FAIL reset_state: valid=%b ready=%b data=%h page=%0d addr=%0d want all 0",
               col_valid, char_ready, col_data, col_page, col_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({char_ready, col_valid, col_page, col_addr} !== 12'h800) begin
      bad++; $display("FAIL after_reset: ready=%b valid=%b page=%0d addr=%0d want 1/0/0/0",
                      char_ready, col_valid, col_page, col_addr);
    end
    m_page = 0; m_col = 0;
  endtask

  task automatic test_char_a();
    run_char(8'h41, 0, -1, -1, 1);
  endtask

  task automatic test_backpressure();
    run_char(8'h42, 1, -1, -1, 0);
  endtask

  task automatic test_wrap();
    pulse_home();
    for (int i = 0; i < 22; i++) run_char(8'h78, 0, -1, -1, 0);
  endtask

  task automatic test_home_emit();
    pulse_home();
    for (int i = 0; i < 7; i++) run_char(8'h0A, 0, -1, -1, 0);
    for (int i = 0; i < 20; i++) run_char(8'h78, 0, -1, -1, 0);
    run_char(8'h78, 0, 1, -1, 0);
    run_char(8'h41, 0, -1, -1, 0);
  endtask

  task automatic test_newline_wrap();
    pulse_home();
    for (int i = 0; i < 7; i++) run_char(8'h0A, 0, -1, -1, 0);
    run_char(8'h78, 0, -1, -1, 0);
    run_char(8'h0D, 0, -1, -1, 0);
    run_char(8'h41, 0, -1, -1, 0);
  endtask

  task automatic test_unknown();
    run_char(8'h05, 0, -1, -1, 0);
    run_char(8'h9C, 1, -1, -1, 0);
  endtask

  task automatic test_reset_mid();
    run_char(8'h41, 0, -1, 2, 0);
    run_char(8'h41, 0, -1, -1, 1);
  endtask

  initial begin
    test_reset();
    test_char_a();
    test_backpressure();
    test_wrap();
    test_home_emit();
    test_newline_wrap();
    test_unknown();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
